// File: rtl/vec_pkg.sv
// Shared defaults and types for the vector register file and its clear engine.
package vec_pkg;
  localparam int VEC_BITS  = 8;
  localparam int VEC_N     = 2;
  localparam int VEC_NREGS = 16;

  typedef logic [VEC_BITS-1:0] lane_t;

  typedef enum logic {CLR_IDLE, CLR_ACTIVE} clr_state_t;
endpackage

// File: rtl/vec_clr_fsm.sv
// Sequential bulk-clear engine: walks every register index once, one per cycle,
// and reports which index to zero on the coming edge.
module vec_clr_fsm
  import vec_pkg::*;
#(
  parameter int NREGS = VEC_NREGS,
  parameter int SELW  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_start,
  output logic            busy,
  output logic            clr_we,
  output logic [SELW-1:0] clr_idx
);

  clr_state_t      state_q;
  logic [SELW-1:0] cnt_q;
  logic            busy_q;

  // busy_q mirrors the state so it can leave the block straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        CLR_IDLE: begin
          if (clr_start) begin
            state_q <= CLR_ACTIVE;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLR_ACTIVE: begin
          if (cnt_q == SELW'(NREGS - 1)) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + SELW'(1);
          end
        end
        default: begin
          state_q <= CLR_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign clr_we  = busy_q;
  assign clr_idx = cnt_q;

endmodule

// File: rtl/vec_reg_file.sv
// Vector register file: one lane-masked write port, two registered read ports
// that see same-edge writes and clears, plus a sequential bulk clear.
module vec_reg_file
  import vec_pkg::*;
#(
  parameter int  BITS  = VEC_BITS,
  parameter int  N     = VEC_N,
  parameter int  NREGS = VEC_NREGS,
  localparam int SELW  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] data_in [N-1:0],
  input  logic [N-1:0]    lane_mask,
  input  logic [SELW-1:0] in_sel,
  input  logic            write,
  input  logic [SELW-1:0] out_sel_a,
  input  logic [SELW-1:0] out_sel_b,
  input  logic            out_en_a,
  input  logic            out_en_b,
  input  logic            clr_start,
  output logic [BITS-1:0] out_a [N-1:0],
  output logic [BITS-1:0] out_b [N-1:0],
  output logic            busy,
  output logic            wr_err
);

  logic [BITS-1:0] mem_q   [NREGS][N-1:0];
  logic [BITS-1:0] mem_d   [NREGS][N-1:0];
  logic [BITS-1:0] rd_a    [N-1:0];
  logic [BITS-1:0] rd_b    [N-1:0];
  logic [BITS-1:0] out_a_q [N-1:0];
  logic [BITS-1:0] out_b_q [N-1:0];
  logic            wr_err_q;
  logic            wr_ok;
  logic            clr_we;
  logic [SELW-1:0] clr_idx;

  vec_clr_fsm #(
    .NREGS (NREGS),
    .SELW  (SELW)
  ) u_clr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_start (clr_start),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_idx   (clr_idx)
  );

  assign wr_ok = write && !busy && (int'(in_sel) < NREGS);

  // mem_d is the post-edge register image; reads tap it to get the bypass for free.
  always_comb begin
    mem_d = mem_q;
    for (int r = 0; r < NREGS; r++) begin
      if (clr_we && (clr_idx == SELW'(r))) begin
        for (int l = 0; l < N; l++) mem_d[r][l] = '0;
      end
      if (wr_ok && (in_sel == SELW'(r))) begin
        for (int l = 0; l < N; l++) begin
          if (lane_mask[l]) mem_d[r][l] = data_in[l];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        for (int l = 0; l < N; l++) mem_q[r][l] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Selects past the last register match nothing and read as zero.
  always_comb begin
    for (int l = 0; l < N; l++) begin
      rd_a[l] = '0;
      rd_b[l] = '0;
    end
    for (int r = 0; r < NREGS; r++) begin
      if (out_sel_a == SELW'(r)) begin
        for (int l = 0; l < N; l++) rd_a[l] = mem_d[r][l];
      end
      if (out_sel_b == SELW'(r)) begin
        for (int l = 0; l < N; l++) rd_b[l] = mem_d[r][l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int l = 0; l < N; l++) begin
        out_a_q[l] <= '0;
        out_b_q[l] <= '0;
      end
      wr_err_q <= 1'b0;
    end else begin
      for (int l = 0; l < N; l++) begin
        out_a_q[l] <= out_en_a ? rd_a[l] : '0;
        out_b_q[l] <= out_en_b ? rd_b[l] : '0;
      end
      wr_err_q <= write && !wr_ok;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_out
      assign out_a[gi] = out_a_q[gi];
      assign out_b[gi] = out_b_q[gi];
    end
  endgenerate

  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_vec_reg_file.sv
// Directed and random checks of vec_reg_file against a register-array model
// that tracks the clear as a remaining-cycle count.
module tb_vec_reg_file;
  import vec_pkg::*;

  localparam int BITS  = 8;
  localparam int N     = 2;
  localparam int NREGS = 16;
  localparam int SELW  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  lane_t           data_in [N-1:0];
  logic [N-1:0]    lane_mask;
  logic [SELW-1:0] in_sel;
  logic            write;
  logic [SELW-1:0] out_sel_a;
  logic [SELW-1:0] out_sel_b;
  logic            out_en_a;
  logic            out_en_b;
  logic            clr_start;
  lane_t           out_a [N-1:0];
  lane_t           out_b [N-1:0];
  logic            busy;
  logic            wr_err;

  int n_vec = 0;
  int n_err = 0;
  int step_no = 0;

  lane_t ref_mem [NREGS][N-1:0];
  int    ref_clr_left;
  int    ref_clr_pos;
  lane_t exp_a [N-1:0];
  lane_t exp_b [N-1:0];
  logic  exp_busy;
  logic  exp_wr_err;

  vec_reg_file #(.BITS(BITS), .N(N), .NREGS(NREGS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .lane_mask (lane_mask),
    .in_sel    (in_sel),
    .write     (write),
    .out_sel_a (out_sel_a),
    .out_sel_b (out_sel_b),
    .out_en_a  (out_en_a),
    .out_en_b  (out_en_b),
    .clr_start (clr_start),
    .out_a     (out_a),
    .out_b     (out_b),
    .busy      (busy),
    .wr_err    (wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one clock edge, evaluated on the pre-edge inputs.
  task automatic model_edge();
    bit acc;
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        for (int l = 0; l < N; l++) ref_mem[r][l] = '0;
      ref_clr_left = 0;
      ref_clr_pos  = 0;
      exp_wr_err   = 1'b0;
      for (int l = 0; l < N; l++) begin
        exp_a[l] = '0;
        exp_b[l] = '0;
      end
    end else begin
      acc = write && (ref_clr_left == 0) && (int'(in_sel) < NREGS);
      if (ref_clr_left > 0) begin
        for (int l = 0; l < N; l++) ref_mem[ref_clr_pos][l] = '0;
        ref_clr_pos++;
        ref_clr_left--;
      end else if (clr_start) begin
        ref_clr_left = NREGS;
        ref_clr_pos  = 0;
      end
      if (acc)
        for (int l = 0; l < N; l++)
          if (lane_mask[l]) ref_mem[in_sel][l] = data_in[l];
      exp_wr_err = write && !acc;
      for (int l = 0; l < N; l++) begin
        exp_a[l] = out_en_a ? ref_mem[out_sel_a][l] : '0;
        exp_b[l] = out_en_b ? ref_mem[out_sel_b][l] : '0;
      end
    end
    exp_busy = (ref_clr_left > 0);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    step_no++;
    $display("step %0d %s: out_a=%h_%h out_b=%h_%h busy=%b wr_err=%b",
             step_no, tag, out_a[1], out_a[0], out_b[1], out_b[0], busy, wr_err);
    check({tag, ".out_a"}, {16'h0, out_a[1], out_a[0]}, {16'h0, exp_a[1], exp_a[0]});
    check({tag, ".out_b"}, {16'h0, out_b[1], out_b[0]}, {16'h0, exp_b[1], exp_b[0]});
    check({tag, ".busy"}, {31'h0, busy}, {31'h0, exp_busy});
    check({tag, ".wr_err"}, {31'h0, wr_err}, {31'h0, exp_wr_err});
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; write = 1'b0; clr_start = 1'b0;
    out_en_a = 1'b0; out_en_b = 1'b0;
    lane_mask = '0; in_sel = '0; out_sel_a = '0; out_sel_b = '0;
    data_in[0] = '0; data_in[1] = '0;
  endtask

  task automatic write_reg(input int r, input lane_t d0, input lane_t d1, input logic [N-1:0] m);
    write = 1'b1; in_sel = SELW'(r); data_in[0] = d0; data_in[1] = d1; lane_mask = m;
    step("write");
    write = 1'b0;
  endtask

  task automatic read_all(input string tag);
    out_en_a = 1'b1; out_en_b = 1'b1;
    for (int r = 0; r < NREGS; r++) begin
      out_sel_a = SELW'(r);
      out_sel_b = SELW'(NREGS - 1 - r);
      step(tag);
    end
    out_en_a = 1'b0; out_en_b = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    idle_inputs();

    // Reset
    rst_n = 1'b0;
    step("reset");
    step("reset");
    rst_n = 1'b1;
    read_all("rd_after_reset");

    // Masked write
    write_reg(1, 8'h0F, 8'h3C, 2'b11);
    write_reg(1, 8'hFF, 8'h7E, 2'b01);
    out_sel_a = 4'd1; out_en_a = 1'b1;
    step("rd_reg1");
    check("masked_lane0", {24'h0, out_a[0]}, 32'hFF);
    check("masked_lane1", {24'h0, out_a[1]}, 32'h3C);

    // Same-edge bypass, then disabled port
    out_sel_a = 4'd2; out_en_a = 1'b1;
    write_reg(2, 8'h01, 8'h00, 2'b11);
    check("bypass_a", {16'h0, out_a[1], out_a[0]}, 32'h0001);
    out_en_a = 1'b0;
    step("rd_disabled");
    check("disabled_a", {16'h0, out_a[1], out_a[0]}, 32'h0000);

    // Dual read
    out_sel_a = 4'd2; out_sel_b = 4'd1; out_en_a = 1'b1; out_en_b = 1'b1;
    step("dual_read");
    check("dual_b", {16'h0, out_b[1], out_b[0]}, 32'h3CFF);
    out_en_a = 1'b0; out_en_b = 1'b0;

    // Bulk clear with a dropped write and an ignored restart
    for (int r = 0; r < NREGS; r++) write_reg(r, 8'hAA, 8'hAA, 2'b11);
    clr_start = 1'b1;
    step("clr_start");
    clr_start = 1'b0;
    busy_cycles = busy ? 1 : 0;
    out_sel_a = 4'd4; out_en_a = 1'b1;
    for (int c = 1; c <= NREGS; c++) begin
      clr_start = (c == 3);
      write     = (c == 5);
      in_sel = 4'd4; data_in[0] = 8'h55; data_in[1] = 8'h55; lane_mask = 2'b11;
      step("clearing");
      if (c == 5) check("clr_wr_err", {31'h0, wr_err}, 32'h1);
      if (busy) busy_cycles++;
    end
    write = 1'b0; clr_start = 1'b0;
    check("busy_len", busy_cycles, NREGS);
    read_all("rd_after_clear");

    // Reset partway through a clear
    for (int r = 0; r < NREGS; r++) write_reg(r, lane_t'(r * 7), lane_t'(r + 100), 2'b11);
    clr_start = 1'b1;
    step("clr_start2");
    clr_start = 1'b0;
    for (int c = 1; c < 7; c++) step("clearing2");
    rst_n = 1'b0;
    step("mid_clear_reset");
    check("abort_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    read_all("rd_after_abort");
    clr_start = 1'b1;
    step("clr_restart");
    check("restart_busy", {31'h0, busy}, 32'h1);
    clr_start = 1'b0;
    for (int c = 0; c < NREGS; c++) step("clearing3");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      clr_start  = ($urandom_range(0, 24) == 0);
      write      = $urandom_range(0, 1) == 1;
      in_sel     = SELW'($urandom);
      lane_mask  = N'($urandom);
      data_in[0] = lane_t'($urandom);
      data_in[1] = lane_t'($urandom);
      out_sel_a  = SELW'($urandom);
      out_sel_b  = SELW'($urandom);
      out_en_a   = $urandom_range(0, 3) != 0;
      out_en_b   = $urandom_range(0, 3) != 0;
      step("random");
    end
    idle_inputs();
    read_all("rd_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
